// File: rtl/bsg_gateway_tx_pkg.sv
// Shared types and constants for the gateway transmit framer.
// Holds the framer state encoding and the default training word.
package bsg_gateway_tx_pkg;

    typedef enum logic [1:0] {
        TRAIN = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2
    } tx_state_e;

    localparam logic [7:0] default_train_pattern_c = 8'hA5;

endpackage

// File: rtl/bsg_gateway_tx_credit_counter.sv
// Credit counter for the gateway transmit framer: reloads on entry to RUN,
// tracks sends against returned tokens, and flags token overflow stickily.
module bsg_gateway_tx_credit_counter #(
    parameter int tokens_p = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            load_i,
    input  logic                            enable_i,
    input  logic                            dec_i,
    input  logic                            inc_i,
    output logic [$clog2(tokens_p+1)-1:0]   credits_o,
    output logic                            error_o
);

    localparam int                credit_w_lp = $clog2(tokens_p+1);
    localparam logic [credit_w_lp-1:0] full_lp = credit_w_lp'(tokens_p);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_o <= '0;
            error_o   <= 1'b0;
        end else if (load_i) begin
            credits_o <= full_lp;
        end else if (enable_i) begin
            if (dec_i && !inc_i) begin
                credits_o <= credits_o - 1'b1;
            end else if (inc_i && !dec_i) begin
                // A token with the receiver buffer already fully credited is lost.
                if (credits_o == full_lp) error_o <= 1'b1;
                else                      credits_o <= credits_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_gateway_tx_framer.sv
// Gateway transmit framer: trains the link, idles for a sync window, then
// sends double-data-rate words to the channel under credit flow control.
module bsg_gateway_tx_framer
    import bsg_gateway_tx_pkg::*;
#(
    parameter int                 width_p         = 8,
    parameter int                 tokens_p        = 16,
    parameter int                 sync_cycles_p   = 4,
    parameter logic [width_p-1:0] train_pattern_p = width_p'(default_train_pattern_c)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            train_i,
    input  logic                            valid_i,
    input  logic [2*width_p-1:0]            data_i,
    output logic                            ready_o,
    input  logic                            token_i,
    output logic [width_p-1:0]              data_r_o,
    output logic [width_p-1:0]              data_f_o,
    output logic                            valid_r_o,
    output logic                            valid_f_o,
    output logic [$clog2(tokens_p+1)-1:0]   credits_o,
    output logic                            error_o
);

    localparam int sync_w_lp = $clog2(sync_cycles_p+1);

    tx_state_e              state_r, state_n;
    logic [sync_w_lp-1:0]   sync_cnt_r, sync_cnt_n;
    logic [width_p-1:0]     data_r_n, data_f_n;
    logic                   valid_r_n, valid_f_n;
    logic                   transfer;
    logic                   load_credits;

    assign ready_o      = (state_r == RUN) && (credits_o != '0) && !train_i;
    assign transfer     = valid_i && ready_o;
    assign load_credits = (state_r == SYNC) && !train_i && (sync_cnt_r == '0);

    // NOTE: every signal gets a default first so no branch can infer a latch.
    always_comb begin
        state_n    = state_r;
        sync_cnt_n = sync_cnt_r;
        data_r_n   = '0;
        data_f_n   = '0;
        valid_r_n  = 1'b0;
        valid_f_n  = 1'b0;
        case (state_r)
            TRAIN: begin
                data_r_n  = train_pattern_p;
                data_f_n  = ~train_pattern_p;
                valid_r_n = 1'b1;
                if (!train_i) begin
                    state_n    = SYNC;
                    sync_cnt_n = sync_w_lp'(sync_cycles_p - 1);
                end
            end
            SYNC: begin
                if (train_i)                 state_n    = TRAIN;
                else if (sync_cnt_r == '0)   state_n    = RUN;
                else                         sync_cnt_n = sync_cnt_r - 1'b1;
            end
            RUN: begin
                if (train_i) state_n = TRAIN;
                if (transfer) begin
                    data_r_n  = data_i[width_p-1:0];
                    data_f_n  = data_i[2*width_p-1:width_p];
                    valid_r_n = 1'b1;
                    valid_f_n = 1'b1;
                end
            end
            default: state_n = TRAIN;
        endcase
    end

    // Channel outputs are registered so they launch cleanly into the ODDR.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= TRAIN;
            sync_cnt_r <= '0;
            data_r_o   <= '0;
            data_f_o   <= '0;
            valid_r_o  <= 1'b0;
            valid_f_o  <= 1'b0;
        end else begin
            state_r    <= state_n;
            sync_cnt_r <= sync_cnt_n;
            data_r_o   <= data_r_n;
            data_f_o   <= data_f_n;
            valid_r_o  <= valid_r_n;
            valid_f_o  <= valid_f_n;
        end
    end

    bsg_gateway_tx_credit_counter #(
        .tokens_p (tokens_p)
    ) credit_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (load_credits),
        .enable_i  (state_r == RUN),
        .dec_i     (transfer),
        .inc_i     (token_i),
        .credits_o (credits_o),
        .error_o   (error_o)
    );

endmodule

// File: tb/tb_bsg_gateway_tx_framer.sv
// Self-checking bench for bsg_gateway_tx_framer: directed link bring-up and
// credit scenarios, then randomized traffic against a behavioural model.
module tb_bsg_gateway_tx_framer;

    localparam int         TOKENS = 16;
    localparam int         SYNC_C = 4;
    localparam logic [7:0] PAT    = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        train_i;
    logic        valid_i;
    logic [15:0] data_i;
    logic        ready_o;
    logic        token_i;
    logic [7:0]  data_r_o;
    logic [7:0]  data_f_o;
    logic        valid_r_o;
    logic        valid_f_o;
    logic [4:0]  credits_o;
    logic        error_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bsg_gateway_tx_framer dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .train_i   (train_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .token_i   (token_i),
        .data_r_o  (data_r_o),
        .data_f_o  (data_f_o),
        .valid_r_o (valid_r_o),
        .valid_f_o (valid_f_o),
        .credits_o (credits_o),
        .error_o   (error_o)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    endtask

    // {ready, error, credits, valid_r, valid_f, data_f, data_r}
    function automatic logic [24:0] pack(input logic rdy, input logic err, input logic [4:0] cr,
                                         input logic vr, input logic vf,
                                         input logic [7:0] df, input logic [7:0] dr);
        return {rdy, err, cr, vr, vf, df, dr};
    endfunction

    function automatic logic [24:0] dut_vec();
        return pack(ready_o, error_o, credits_o, valid_r_o, valid_f_o, data_f_o, data_r_o);
    endfunction

    // Behavioural model: training flag, count of quiet cycles seen, credit balance.
    bit         m_training = 1'b1;
    int         m_quiet    = 0;
    int         m_credits  = 0;
    bit         m_error    = 1'b0;
    logic [7:0] m_dr = '0, m_df = '0;
    logic       m_vr = 1'b0, m_vf = 1'b0;

    function automatic bit m_ready();
        return !m_training && (m_quiet == SYNC_C) && (m_credits > 0) && !train_i;
    endfunction

    always @(posedge clk or negedge reset_n_i) begin
        bit accept;
        if (!reset_n_i) begin
            m_training = 1'b1; m_quiet = 0; m_credits = 0; m_error = 1'b0;
            m_dr = '0; m_df = '0; m_vr = 1'b0; m_vf = 1'b0;
        end else if (m_training) begin
            m_dr = PAT; m_df = ~PAT; m_vr = 1'b1; m_vf = 1'b0;
            if (!train_i) begin
                m_training = 1'b0;
                m_quiet    = 0;
            end
        end else if (m_quiet < SYNC_C) begin
            m_dr = '0; m_df = '0; m_vr = 1'b0; m_vf = 1'b0;
            if (train_i) m_training = 1'b1;
            else begin
                m_quiet++;
                if (m_quiet == SYNC_C) m_credits = TOKENS;
            end
        end else begin
            accept = valid_i && m_ready();
            m_dr = accept ? data_i[7:0]  : 8'h00;
            m_df = accept ? data_i[15:8] : 8'h00;
            m_vr = accept;
            m_vf = accept;
            if (token_i && !accept && m_credits == TOKENS) m_error = 1'b1;
            else m_credits = m_credits + int'(token_i) - int'(accept);
            if (train_i) m_training = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("model_compare", dut_vec(),
              pack(m_ready(), m_error, 5'(m_credits), m_vr, m_vf, m_df, m_dr));
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    logic [15:0] words [16];

    initial begin
        int pending;
        int train_left;
        int rst_left;

        reset_n_i = 1'b1; train_i = 1'b1; valid_i = 1'b0; data_i = '0; token_i = 1'b0;
        #2 reset_n_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", dut_vec(), 25'h0);
        #1 reset_n_i = 1'b1;

        // Training: pattern on the rising half, its complement on the falling half.
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("train_word", dut_vec(), pack(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h5A, 8'hA5));
        end

        #1 train_i = 1'b0;
        cycle();
        check("last_train_word", dut_vec(), pack(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h5A, 8'hA5));
        for (int q = 0; q < 4; q++) begin
            cycle();
            if (q < 3) check("sync_quiet", dut_vec(), 25'h0);
            else       check("run_entry", dut_vec(), pack(1'b1, 1'b0, 5'd16, 1'b0, 1'b0, 8'h00, 8'h00));
        end

        // Stream until credits run out.
        for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            #1 valid_i = 1'b1; data_i = words[i];
            cycle();
            check("stream_word", {valid_r_o, valid_f_o, data_f_o, data_r_o, credits_o},
                  {1'b1, 1'b1, words[i], 5'(15 - i)});
        end
        #1 data_i = 16'hBEEF;
        #1 check("ready_exhausted", {ready_o, credits_o}, {1'b0, 5'd0});
        cycle();
        check("idle_after_exhaust", {valid_r_o, valid_f_o, data_r_o}, 10'h0);

        // Token returns, then simultaneous send and token.
        #1 valid_i = 1'b0; token_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("token_credit", credits_o, 5'(k + 1));
        end
        #1 valid_i = 1'b1; data_i = words[0];
        cycle();
        check("send_and_token", {credits_o, data_f_o, data_r_o}, {5'd3, words[0]});
        #1 valid_i = 1'b0;
        cycle();
        check("token_alone", credits_o, 5'd4);
        repeat (12) cycle();
        check("credits_full", {error_o, credits_o}, {1'b0, 5'd16});
        cycle();
        check("overflow_error", {error_o, credits_o}, {1'b1, 5'd16});
        #1 token_i = 1'b0;
        repeat (3) cycle();
        check("error_sticky", error_o, 1'b1);

        // Retrain in the middle of a stream.
        #1 valid_i = 1'b1; data_i = 16'($urandom);
        cycle();
        #1 data_i = 16'($urandom);
        cycle();
        #1 data_i = 16'($urandom);
        cycle();
        check("stream_credits", credits_o, 5'd13);
        #1 train_i = 1'b1;
        #1 check("train_blocks_ready", ready_o, 1'b0);
        cycle();
        check("no_send_on_train", {valid_r_o, valid_f_o, credits_o}, {2'b00, 5'd13});
        cycle();
        check("retrain_word", {valid_r_o, valid_f_o, data_f_o, data_r_o}, {2'b10, 8'h5A, 8'hA5});
        #1 train_i = 1'b0; valid_i = 1'b0;
        repeat (5) cycle();
        check("rerun_reload", {ready_o, error_o, credits_o}, {1'b1, 1'b1, 5'd16});

        // Asynchronous reset with a transfer pending.
        #1 valid_i = 1'b1; data_i = 16'h1234;
        #1 reset_n_i = 1'b0;
        #1 check("async_reset", dut_vec(), 25'h0);
        @(negedge clk);
        #1 reset_n_i = 1'b1; valid_i = 1'b0; train_i = 1'b1;
        cycle();
        check("post_reset_train", {credits_o, valid_r_o, data_r_o}, {5'd0, 1'b1, 8'hA5});
        #1 train_i = 1'b0;
        cycle();

        // Randomized traffic; the model compare process checks every cycle.
        pending = 0; train_left = 0; rst_left = 0;
        repeat (1500) begin
            #1;
            if (pending == 0) begin
                valid_i = ($urandom_range(0, 99) < 60);
                data_i  = 16'($urandom);
            end
            token_i = ($urandom_range(0, 99) < 35);
            if (train_left > 0) train_left--;
            else if ($urandom_range(0, 149) == 0) train_left = $urandom_range(1, 12);
            train_i = (train_left > 0);
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 499) == 0) rst_left = 2;
            reset_n_i = !(rst_left > 0);
            #1 pending = int'(valid_i && !ready_o);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bsg_gateway_tx_framer.md
BSG_GATEWAY_TX_FRAMER -- requirements
Module: bsg_gateway_tx_framer

Interface
REQ-001 Parameter width_p, default 8: channel data bits per clock edge.
REQ-002 Parameter tokens_p, default 16: receiver buffer depth, which is also the maximum credit count.
REQ-003 Parameter sync_cycles_p, default 4: number of quiet cycles between training and run.
REQ-004 Parameter train_pattern_p, default 8'hA5 (width_p bits): training word.
REQ-005 clk_i  in  1  core/channel clock; all logic is on its rising edge.
REQ-006 reset_n_i  in  1  reset, asynchronous assert, active-low.
REQ-007 train_i  in  1  training request, level; synchronous to clk_i.
REQ-008 valid_i  in  1  upstream word valid.
REQ-009 data_i  in  2*width_p  word; [width_p-1:0] goes on the rising edge, the upper half on the falling edge.
REQ-010 ready_o  out  1  block accepts data_i this cycle.
REQ-011 token_i  in  1  one-cycle credit-return pulse, already synchronized to clk_i.
REQ-012 data_r_o  out  width_p  registered rising-edge data, to ODDR and then the output IODELAY.
REQ-013 data_f_o  out  width_p  registered falling-edge data.
REQ-014 valid_r_o / valid_f_o  out  1 each  registered channel-valid bits for each edge.
REQ-015 credits_o  out  $clog2(tokens_p+1)  current credit count.
REQ-016 error_o  out  1  sticky credit-overflow flag.

Function
REQ-017 The FSM shall have three states: TRAIN, SYNC and RUN.
REQ-018 TRAIN: data_r_o=train_pattern_p, data_f_o=~train_pattern_p, valid_r_o=1, valid_f_o=0, ready_o=0.
REQ-019 TRAIN->SYNC shall occur on the first cycle with train_i=0; the sync counter loads sync_cycles_p-1 on that transition.
REQ-020 SYNC: all data and valid outputs 0, ready_o=0; counter decrements each cycle.
REQ-021 SYNC->RUN shall occur when the counter is 0, giving exactly sync_cycles_p SYNC cycles.
REQ-022 train_i=1 in SYNC or RUN shall cause a transition to TRAIN on the next edge.
REQ-023 ready_o shall be combinational: (state==RUN) & (credits_o!=0) & ~train_i.
REQ-024 A transfer occurs when valid_i & ready_o; valid_i may be held without ready_o, and data_i shall then stay stable.
REQ-025 On a transfer, outputs shall update at the next edge: data_r_o/data_f_o = data_i halves, valid_r_o=valid_f_o=1 (latency 1).
REQ-026 A RUN cycle with no transfer shall drive data 0 and valids 0 at the next edge.
REQ-027 Credits shall reload to tokens_p on the SYNC->RUN edge; any token_i in that cycle is ignored.
REQ-028 In RUN, credits shall be decremented on a transfer and incremented on token_i; both in one cycle leaves credits unchanged.
REQ-029 If token_i arrives with credits==tokens_p and no transfer, credits shall stay at tokens_p and error_o shall set.
REQ-030 token_i in TRAIN or SYNC shall be ignored and shall not set error_o.
REQ-031 error_o shall clear only on reset.
REQ-032 Credits shall never underflow; this follows from REQ-023.

Reset
REQ-033 While reset_n_i=0: state=TRAIN, credits_o=0, sync counter=0, error_o=0, all data/valid outputs 0, ready_o=0.
REQ-034 The first edge after release shall drive the TRAIN outputs of REQ-018.
REQ-035 Reset mid-transfer shall discard the in-flight word with no recovery; credits restart at 0 until the next SYNC->RUN.

Structure
REQ-036 Package bsg_gateway_tx_pkg shall hold the state enum (TRAIN/SYNC/RUN) and the default training pattern constant.
REQ-037 Sub-module bsg_gateway_tx_credit_counter shall hold the load/inc/dec/saturate/error logic (REQ-027..031).
REQ-038 The framer shall instantiate the credit counter once.

Verification
REQ-039 Reset, then train_i=1 for 10 cycles -> data_r_o=8'hA5, data_f_o=8'h5A, valid_r_o=1, valid_f_o=0 each cycle; ready_o=0.
REQ-040 Drop train_i -> exactly 4 zero cycles, then RUN with credits_o=16 and ready_o=1.
REQ-041 Stream 16 words with valid_i=1 and no tokens -> 16 outputs each one cycle after acceptance; credits_o=0; ready_o=0 on the 17th cycle.
REQ-042 With credits_o=3, transfer and token_i together -> credits_o stays 3; token alone -> 4.
REQ-043 Credits full (16), pulse token_i -> credits_o=16 and error_o=1, sticky until reset.
REQ-044 Raise train_i mid-stream and assert reset_n_i=0 mid-transfer -> TRAIN next edge with ready_o=0 the same cycle; on reset, outputs clear asynchronously with credits_o=0.
